// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among NUM_UNITS
// execution units; grants combinationally, presents the winner one cycle later.
module wb_port_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN      = 32,
  parameter int ID_W      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_UNITS-1:0]              done,
  input  logic [NUM_UNITS*5-1:0]            unit_rd_addr,
  input  logic [NUM_UNITS*XLEN-1:0]         unit_rd_data,
  input  logic [NUM_UNITS*ID_W-1:0]         unit_id,
  output logic [NUM_UNITS-1:0]              ack,
  output logic                              valid_write,
  output logic [4:0]                        rd_addr,
  output logic [XLEN-1:0]                   rd_data,
  output logic [ID_W-1:0]                   id,
  output logic [$clog2(NUM_UNITS)-1:0]      rr_ptr
);

  localparam int PTR_W = $clog2(NUM_UNITS);
  localparam logic [PTR_W:0]   NUM_P = (PTR_W+1)'(NUM_UNITS);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(NUM_UNITS - 1);

  logic [PTR_W-1:0]     rr_ptr_r;
  logic                 valid_write_r;
  logic [4:0]           rd_addr_r;
  logic [XLEN-1:0]      rd_data_r;
  logic [ID_W-1:0]      id_r;

  logic                 grant_s;
  logic [PTR_W-1:0]     win_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W-1:0]     idx_s;
  logic                 take_s;
  logic [NUM_UNITS-1:0] ack_s;
  logic [4:0]           sel_addr_s;
  logic [XLEN-1:0]      sel_data_s;
  logic [ID_W-1:0]      sel_id_s;
  logic [PTR_W-1:0]     ptr_next_s;

  // Scan from rr_ptr upward (modulo NUM_UNITS) and take the first pending unit
  always_comb begin
    grant_s = 1'b0;
    win_s   = {PTR_W{1'b0}};
    sum_s   = {(PTR_W+1){1'b0}};
    idx_s   = {PTR_W{1'b0}};
    take_s  = 1'b0;
    ack_s   = {NUM_UNITS{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (sum_s >= NUM_P) begin
        sum_s = sum_s - NUM_P;
      end else begin
        sum_s = sum_s;
      end
      idx_s   = sum_s[PTR_W-1:0];
      take_s  = done[idx_s] & ~flush & ~grant_s;
      win_s   = take_s ? idx_s : win_s;
      grant_s = grant_s | take_s;
    end
    if (grant_s) begin
      ack_s[win_s] = 1'b1;
    end else begin
      ack_s = {NUM_UNITS{1'b0}};
    end
  end

  // One-hot AND-OR mux of the winning unit's completion fields
  always_comb begin
    sel_addr_s = 5'd0;
    sel_data_s = {XLEN{1'b0}};
    sel_id_s   = {ID_W{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      sel_addr_s = sel_addr_s | ({5{ack_s[k]}}    & unit_rd_addr[k*5 +: 5]);
      sel_data_s = sel_data_s | ({XLEN{ack_s[k]}} & unit_rd_data[k*XLEN +: XLEN]);
      sel_id_s   = sel_id_s   | ({ID_W{ack_s[k]}} & unit_id[k*ID_W +: ID_W]);
    end
  end

  // Priority moves just past the winner, wrapping at the last unit
  always_comb begin
    if (win_s == LAST_P) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = win_s + PTR_W'(1);
    end
  end

  // Writeback register stage; x0 destinations are consumed without a strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r      <= {PTR_W{1'b0}};
      valid_write_r <= 1'b0;
      rd_addr_r     <= 5'd0;
      rd_data_r     <= {XLEN{1'b0}};
      id_r          <= {ID_W{1'b0}};
    end else if (grant_s) begin
      rr_ptr_r      <= ptr_next_s;
      valid_write_r <= (sel_addr_s != 5'd0);
      rd_addr_r     <= sel_addr_s;
      rd_data_r     <= sel_data_s;
      id_r          <= sel_id_s;
    end else begin
      valid_write_r <= 1'b0;
    end
  end

  // Grants are forced off while reset is held, independent of the clock
  assign ack         = ack_s & {NUM_UNITS{rst}};
  assign valid_write = valid_write_r;
  assign rd_addr     = rd_addr_r;
  assign rd_data     = rd_data_r;
  assign id          = id_r;
  assign rr_ptr      = rr_ptr_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter (4 units, 32-bit data, 2-bit id).
module tb_wb_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   done;
  logic [19:0]  unit_rd_addr;
  logic [127:0] unit_rd_data;
  logic [7:0]   unit_id;
  logic [3:0]   ack;
  logic         valid_write;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [1:0]   id;
  logic [1:0]   rr_ptr;

  logic [4:0]  u_addr [4];
  logic [31:0] u_data [4];
  logic [1:0]  u_id   [4];

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  i;
  } wr_t;

  wr_t        exp_q [$];
  wr_t        m_last;
  logic [1:0] m_ptr;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] rr_seq [4];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      unit_rd_addr[i*5 +: 5]   = u_addr[i];
      unit_rd_data[i*32 +: 32] = u_data[i];
      unit_id[i*2 +: 2]        = u_id[i];
    end
  end

  wb_port_arbiter #(.NUM_UNITS(4), .XLEN(32), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .done(done),
    .unit_rd_addr(unit_rd_addr), .unit_rd_data(unit_rd_data), .unit_id(unit_id),
    .ack(ack), .valid_write(valid_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .id(id), .rr_ptr(rr_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One arbitration cycle: check grant against the model, then the registered write
  task automatic cycle(input string tag);
    logic [3:0] ea;
    logic [1:0] w;
    int idx;
    wr_t e;
    #1;
    ea = 4'b0000;
    w  = 2'd0;
    if (!flush) begin
      for (int k = 0; k < 4; k++) begin
        idx = (int'(m_ptr) + k) % 4;
        if (done[idx] && ea == 4'b0000) begin
          ea[idx] = 1'b1;
          w = 2'(idx);
        end
      end
    end
    chk({tag, "_ack"}, 64'(ack), 64'(ea));
    chk({tag, "_ptr"}, 64'(rr_ptr), 64'(m_ptr));
    if (ea != 4'b0000) begin
      m_last.v = (u_addr[w] != 5'd0);
      m_last.a = u_addr[w];
      m_last.d = u_data[w];
      m_last.i = u_id[w];
      m_ptr    = w + 2'd1;
    end else begin
      m_last.v = 1'b0;
    end
    exp_q.push_back(m_last);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(valid_write), 64'(e.v));
      chk({tag, "_addr"}, 64'(rd_addr), 64'(e.a));
      chk({tag, "_data"}, 64'(rd_data), 64'(e.d));
      chk({tag, "_id"}, 64'(id), 64'(e.i));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_valid"}, 64'(valid_write), 64'd0);
    chk({tag, "_ptr"}, 64'(rr_ptr), 64'd0);
    chk({tag, "_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_id"}, 64'(id), 64'd0);
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    done  = 4'b1111;
    u_addr[0] = 5'd3;  u_data[0] = 32'h1111_0000; u_id[0] = 2'd0;
    u_addr[1] = 5'd7;  u_data[1] = 32'h2222_0001; u_id[1] = 2'd1;
    u_addr[2] = 5'd12; u_data[2] = 32'h3333_0002; u_id[2] = 2'd2;
    u_addr[3] = 5'd31; u_data[3] = 32'h4444_0003; u_id[3] = 2'd3;
    m_ptr  = 2'd0;
    m_last = '0;
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;

    // Reset held with all units requesting
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b1;
    #1;
    chk("rst_rel_ack", 64'(ack), 64'(4'b0001));
    cycle("rst_rel");
    chk("rst_rel_wr_data", 64'(rd_data), 64'(32'h1111_0000));

    // Round robin with every unit re-requesting
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("rr_seq_ack", 64'(ack), 64'(rr_seq[s]));
      cycle("rr");
      chk("rr_valid", 64'(valid_write), 64'd1);
    end

    // Single requester on unit 2
    done = 4'b0100;
    u_addr[2] = 5'd5; u_data[2] = 32'hDEAD_BEEF; u_id[2] = 2'd3;
    #1;
    chk("single_ack", 64'(ack), 64'(4'b0100));
    cycle("single");
    chk("single_data", 64'(rd_data), 64'(32'hDEAD_BEEF));
    chk("single_ptr", 64'(rr_ptr), 64'd3);

    // x0 destination is granted but not written
    done = 4'b0010;
    u_addr[1] = 5'd0;
    cycle("x0");
    chk("x0_valid", 64'(valid_write), 64'd0);
    chk("x0_ptr", 64'(rr_ptr), 64'd2);

    // Idle cycle, then flush suppressing grants
    done = 4'b0000;
    u_addr[1] = 5'd9;
    cycle("idle");
    done  = 4'b0011;
    flush = 1'b1;
    cycle("flush");
    chk("flush_ptr", 64'(rr_ptr), 64'd2);
    flush = 1'b0;
    #1;
    chk("post_flush_ack", 64'(ack), 64'(4'b0001));
    cycle("post_flush");

    // Continuous grants then asynchronous reset between edges
    done = 4'b1111;
    cycle("stream0");
    cycle("stream1");
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    check_reset_state("async_rst_hold");
    exp_q.delete();
    m_ptr  = 2'd0;
    m_last = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_ack", 64'(ack), 64'(4'b0001));
    cycle("rst2");
    cycle("rst2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
